// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtracter: one DIGIT-wide adder slice walks the operands
// from the least-significant digit upward, with a start/busy/done handshake.
module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshake: start is accepted only in IDLE or DONE; busy is high from the
  // accepting edge until the last digit is written; done then pulses for one
  // cycle and ans/flags hold until the next accepting edge.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s;
  logic             c;
  logic [WIDTH-1:0] ans_next;
  logic             msb_cin;
  logic             unused_cmd;

  assign unused_cmd = ^command[2:1];

  always_comb begin
    a_dig    = a_reg[int'(cnt)*DIGIT +: DIGIT];
    b_dig    = b_reg[int'(cnt)*DIGIT +: DIGIT];
    {c, s}   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    ans_next = ans;
    ans_next[int'(cnt)*DIGIT +: DIGIT] = s;
    // Carry into the sign bit, recovered from the sign-bit sum on the top digit.
    msb_cin  = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ s[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ans      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= opA;
            b_reg <= command[0] ? ~opB : opB;
            carry <= command[0];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          ans   <= ans_next;
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            carryout <= c;
            overflow <= msb_cin ^ c;
            zero     <= (ans_next == '0);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised multi-cycle adder/subtracter and the next generation of the team's 32-bit ripple adder/subtracter. It processes operands DIGIT bits per clock through one DIGIT-wide adder slice, trading latency for area. A start/busy/done handshake lets the ALU or a microcoded multiply/divide sequencer drive it. Flags follow the existing ALU conventions: carryout, signed overflow, and an added zero flag.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock (slice width); 1 <= DIGIT <= WIDTH.
N (derived, localparam), WIDTH/DIGIT, number of processing cycles.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
command  input  3  operation select; command[0]=0 ADD, command[0]=1 SUB (A-B); command[2:1] ignored.
opA  input  WIDTH  operand A, captured on the accepting edge.
opB  input  WIDTH  operand B, captured on the accepting edge.
busy  output  1  high while digits are being processed.
done  output  1  one-cycle pulse: results valid.
ans  output  WIDTH  result.
carryout  output  1  carry out of bit WIDTH-1.
overflow  output  1  signed two's-complement overflow.
zero  output  1  ans == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. At a rising edge with reset=1: state=IDLE; busy=0, done=0, ans=0, carryout=0, overflow=0, zero=0; internal counter, carry and operand registers are cleared. Reset has priority over start.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 (edge E0): latch opA into a_reg; latch B as opB or ~opB (command[0]=1); carry=command[0]; cnt=0; go to RUN. busy=1 from E0; done=0.
- IDLE + start=0: stay in IDLE. DONE + start=0: go to IDLE at the next edge (done=0).
- RUN, edge Ek (k=1..N): compute {c, s} = a_reg[digit cnt] + b_reg[digit cnt] + carry at DIGIT+1 bits; write s into ans digit cnt; carry=c; cnt++.
- The last digit (cnt=N-1) also sets:
  - carryout = c.
  - overflow = carry into bit WIDTH-1 XOR c.
  - zero = (completed ans == 0).
  - state goes to DONE; busy=0; done=1.
- Latency: done is high in the cycle after edge E_N, i.e. N+1 edges after the accepting edge. With WIDTH=32, DIGIT=4 that is 9 edges. Back-to-back start in DONE gives one result every N+1 cycles.
- start in RUN is ignored; operand and command inputs are don't-care after E0.
- ans, carryout, overflow and zero are held stable from done until the next accepting edge. On acceptance they may change digit by digit and are invalid until done.
- Reset mid-RUN aborts the operation: no done pulse, and all outputs clear at that edge.
- Arithmetic is modulo 2^WIDTH.
  - SUB is A + ~B + 1, so carryout=1 means no borrow (A >= B unsigned).
  - DIGIT=WIDTH degenerates to N=1: a single RUN cycle.

Test Plan:
- WIDTH=32, DIGIT=4: ADD 7+5, start at E0 -> busy edges E0..E8; done=1 exactly one cycle after E8; ans=0x0000000C, carryout=0, overflow=0, zero=0.
- SUB 5-7 -> ans=0xFFFFFFFE, carryout=0, overflow=0. SUB 7-5 -> ans=2, carryout=1.
- ADD 0x7FFFFFFF+1 -> ans=0x80000000, overflow=1, carryout=0. ADD 0xFFFFFFFF+1 -> ans=0, carryout=1, overflow=0, zero=1.
- Change opA/opB/command and pulse start at E3 during RUN -> ignored; result equals the E0 operands; back-to-back start in DONE accepted, second done N+1 edges later.
- Assert reset at E4 of a run -> no done, all outputs 0 next cycle. Subsequent ADD 1+1 gives ans=2 with normal latency.
- WIDTH=16, DIGIT=16: SUB 0x8000-0x0001 -> done 2 edges after start; ans=0x7FFF, carryout=1, overflow=1.
